// File: rtl/write_reg_pipe.sv
// write_reg_pipe
//   Carries decoded write-register records through the E, M and W stages,
//   resolves each record's final value (ALU result, memory load data, or the
//   value carried from decode), drives the GPR write port from W, and answers
//   two decode-side operand queries with forwarded data or a stall request.
//
//   Build option: define WRITE_REG_FWD_EN to enable operand forwarding.
//   Without it, hit/data are tied low and busy is raised for any in-flight
//   writer of the queried register (pure interlock).
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_ready     decode handshake, record on in_wr
//   alu_result            ALU output for the record in E
//   mem_rvalid/mem_rdata  load response for the record in M
//   flush                 kill E and M (W still commits)
//   ra1/ra2               operand queries -> fwd*_hit / fwd*_data / fwd*_busy
//   rf_we/rf_waddr/rf_wdata  register file write port, driven from W

package write_reg_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  creg_addr_t;

  typedef enum logic [1:0] {
    SRC_NOP = 2'd0,
    SRC_ALU = 2'd1,
    SRC_MEM = 2'd2
  } wr_src_e;

  typedef struct packed {
    logic       valid;
    wr_src_e    src;
    word_t      value;
    creg_addr_t dst;
  } write_reg_t;
endpackage

module write_reg_pipe
  import write_reg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  write_reg_t in_wr,
  input  word_t      alu_result,
  input  logic       mem_rvalid,
  input  word_t      mem_rdata,
  input  logic       flush,
  input  creg_addr_t ra1,
  input  creg_addr_t ra2,
  output logic       fwd1_hit,
  output logic       fwd2_hit,
  output word_t      fwd1_data,
  output word_t      fwd2_data,
  output logic       fwd1_busy,
  output logic       fwd2_busy,
  output logic       rf_we,
  output creg_addr_t rf_waddr,
  output word_t      rf_wdata
);

  // E stage
  logic       e_valid_q, e_valid_d;
  write_reg_t e_wr_q, e_wr_d;
  // M stage
  logic       m_valid_q, m_valid_d;
  write_reg_t m_wr_q, m_wr_d;
  logic       m_have_q, m_have_d;
  // W stage: only the fields the write port and forwarding need
  logic       w_valid_q, w_valid_d;
  logic       w_wr_valid_q, w_wr_valid_d;
  creg_addr_t w_dst_q, w_dst_d;
  word_t      w_value_q, w_value_d;
  // A flushed load is still outstanding; its response must be swallowed.
  logic       drop_q, drop_d;

  logic m_mem_wait;
  logic mem_take;
  logic m_adv;
  logic e_adv;

  assign m_mem_wait = m_valid_q & (m_wr_q.src == SRC_MEM) & ~m_have_q;
  assign mem_take   = m_mem_wait & mem_rvalid & ~drop_q;
  assign m_adv      = ~m_mem_wait | mem_take;
  assign e_adv      = ~m_valid_q | m_adv;
  assign in_ready   = (~e_valid_q | e_adv) & ~flush;

  always_comb begin
    e_valid_d    = e_valid_q;
    e_wr_d       = e_wr_q;
    m_valid_d    = m_valid_q;
    m_wr_d       = m_wr_q;
    m_have_d     = m_have_q;
    drop_d       = drop_q;

    // W retires every cycle; it is reloaded only when M hands over a record.
    w_valid_d    = m_valid_q & m_adv & ~flush;
    w_wr_valid_d = m_wr_q.valid;
    w_dst_d      = m_wr_q.dst;
    w_value_d    = mem_take ? mem_rdata : m_wr_q.value;

    if (flush) begin
      m_valid_d = 1'b0;
      m_have_d  = 1'b0;
    end else if (m_adv) begin
      m_valid_d = e_valid_q;
      m_wr_d    = e_wr_q;
      m_have_d  = (e_wr_q.src != SRC_MEM);
      if (e_wr_q.src == SRC_ALU) begin
        m_wr_d.value = alu_result;
      end
    end

    if (flush) begin
      e_valid_d = 1'b0;
    end else if (e_adv) begin
      e_valid_d = in_valid;
      e_wr_d    = in_wr;
    end

    // Clear first so a flush landing on the same cycle re-arms the drop.
    if (drop_q & mem_rvalid) begin
      drop_d = 1'b0;
    end
    if (flush & m_mem_wait & ~mem_take) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_valid_q    <= 1'b0;
      e_wr_q       <= '0;
      m_valid_q    <= 1'b0;
      m_wr_q       <= '0;
      m_have_q     <= 1'b0;
      w_valid_q    <= 1'b0;
      w_wr_valid_q <= 1'b0;
      w_dst_q      <= '0;
      w_value_q    <= '0;
      drop_q       <= 1'b0;
    end else begin
      e_valid_q    <= e_valid_d;
      e_wr_q       <= e_wr_d;
      m_valid_q    <= m_valid_d;
      m_wr_q       <= m_wr_d;
      m_have_q     <= m_have_d;
      w_valid_q    <= w_valid_d;
      w_wr_valid_q <= w_wr_valid_d;
      w_dst_q      <= w_dst_d;
      w_value_q    <= w_value_d;
      drop_q       <= drop_d;
    end
  end

  assign rf_we    = w_valid_q & w_wr_valid_q & (w_dst_q != '0);
  assign rf_waddr = w_dst_q;
  assign rf_wdata = w_value_q;

  // r0 is never a real destination, so it never matches.
  function automatic logic stage_match(input logic v, input logic wv,
                                       input creg_addr_t dst, input creg_addr_t ra);
    return v & wv & (dst != '0) & (dst == ra);
  endfunction

  logic [1:0][4:0]  ra_v;
  logic [1:0]       hit_v;
  logic [1:0]       busy_v;
  logic [1:0][31:0] data_v;
  logic [1:0]       e_m, m_m, w_m;

  assign ra_v = {ra2, ra1};

  always_comb begin
    hit_v  = '0;
    busy_v = '0;
    data_v = '0;
    e_m    = '0;
    m_m    = '0;
    w_m    = '0;
    for (int q = 0; q < 2; q++) begin
      e_m[q] = stage_match(e_valid_q, e_wr_q.valid, e_wr_q.dst, ra_v[q]);
      m_m[q] = stage_match(m_valid_q, m_wr_q.valid, m_wr_q.dst, ra_v[q]);
      w_m[q] = stage_match(w_valid_q, w_wr_valid_q, w_dst_q, ra_v[q]);
`ifdef WRITE_REG_FWD_EN
      // Youngest writer wins. M never forwards mem_rdata directly, which
      // keeps the load data path out of the decode timing path.
      if (e_m[q]) begin
        case (e_wr_q.src)
          SRC_NOP: begin
            hit_v[q]  = 1'b1;
            data_v[q] = e_wr_q.value;
          end
          SRC_ALU: begin
            hit_v[q]  = 1'b1;
            data_v[q] = alu_result;
          end
          default: busy_v[q] = 1'b1;
        endcase
      end else if (m_m[q]) begin
        if (m_have_q) begin
          hit_v[q]  = 1'b1;
          data_v[q] = m_wr_q.value;
        end else begin
          busy_v[q] = 1'b1;
        end
      end else if (w_m[q]) begin
        hit_v[q]  = 1'b1;
        data_v[q] = w_value_q;
      end
`else
      busy_v[q] = e_m[q] | m_m[q] | w_m[q];
`endif
    end
  end

  assign fwd1_hit  = hit_v[0];
  assign fwd2_hit  = hit_v[1];
  assign fwd1_data = data_v[0];
  assign fwd2_data = data_v[1];
  assign fwd1_busy = busy_v[0];
  assign fwd2_busy = busy_v[1];

endmodule

// File: tb/tb_write_reg_pipe.sv
module tb_write_reg_pipe;
  import write_reg_pkg::*;

`ifdef WRITE_REG_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  write_reg_t in_wr;
  word_t      alu_result;
  logic       mem_rvalid;
  word_t      mem_rdata;
  logic       flush;
  creg_addr_t ra1, ra2;
  logic       fwd1_hit, fwd2_hit, fwd1_busy, fwd2_busy;
  word_t      fwd1_data, fwd2_data;
  logic       rf_we;
  creg_addr_t rf_waddr;
  word_t      rf_wdata;

  write_reg_pipe dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_wr(in_wr),
    .alu_result(alu_result), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .flush(flush), .ra1(ra1), .ra2(ra2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .fwd1_busy(fwd1_busy), .fwd2_busy(fwd2_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    creg_addr_t addr;
    word_t      data;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
  endtask

  task automatic expect_wr(input creg_addr_t a, input word_t d);
    exp_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Expectations are given for the forwarding build; without forwarding the
  // port must show hit=0, data=0 and busy = "some in-flight writer matches".
  task automatic chk_fwd(input string nm, input int q, input logic e_hit,
                         input word_t e_data, input logic e_busy, input logic e_any);
    logic  h, b, xh, xb;
    word_t d, xd;
    if (q == 1) begin h = fwd1_hit; d = fwd1_data; b = fwd1_busy; end
    else        begin h = fwd2_hit; d = fwd2_data; b = fwd2_busy; end
    xh = FWD_ON ? e_hit  : 1'b0;
    xd = FWD_ON ? e_data : 32'h0;
    xb = FWD_ON ? e_busy : e_any;
    check({nm, "_hit"},  32'(h), 32'(xh));
    check({nm, "_data"}, d, xd);
    check({nm, "_busy"}, 32'(b), 32'(xb));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write-port monitor: every cycle with rf_we high retires one record.
  exp_t got;
  always @(negedge clk) begin
    if (!reset && rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got r%0d=0x%08h, want no write", rf_waddr, rf_wdata);
      end else begin
        got = exp_q.pop_front();
        check("wr_addr", 32'(rf_waddr), 32'(got.addr));
        check("wr_data", rf_wdata, got.data);
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_wr = '0; alu_result = '0;
    mem_rvalid = 1'b0; mem_rdata = '0; flush = 1'b0; ra1 = '0; ra2 = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_rf_we",    32'(rf_we), 32'd0);
    check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    chk_fwd("rst_fwd1", 1, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // ADDU r5 <- 0x1234, observed in E, M and W, then gone
    in_wr = '{valid: 1'b1, src: SRC_ALU, value: 32'h0, dst: 5'd5};
    in_valid = 1'b1;
    expect_wr(5'd5, 32'h1234);
    #1 check("t1_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; alu_result = 32'h1234; ra1 = 5'd5; #1;
    chk_fwd("t1_E", 1, 1'b1, 32'h1234, 1'b0, 1'b1);
    tick();
    alu_result = 32'hFFFF_0000; #1;
    chk_fwd("t1_M", 1, 1'b1, 32'h1234, 1'b0, 1'b1);
    tick(); #1;
    chk_fwd("t1_W", 1, 1'b1, 32'h1234, 1'b0, 1'b1);
    tick(); #1;
    chk_fwd("t1_done", 1, 1'b0, 32'h0, 1'b0, 1'b0);

    // LW r8 stalls in M, ADDU r9 queued behind it in E
    alu_result = 32'h99; ra1 = 5'd8;
    in_wr = '{valid: 1'b1, src: SRC_MEM, value: 32'h0, dst: 5'd8};
    in_valid = 1'b1;
    expect_wr(5'd8, 32'hDEAD_BEEF);
    expect_wr(5'd9, 32'h99);
    tick();
    in_wr = '{valid: 1'b1, src: SRC_ALU, value: 32'h0, dst: 5'd9};
    tick();
    in_valid = 1'b0; #1;
    check("t2_in_ready_stall", 32'(in_ready), 32'd0);
    chk_fwd("t2_busy", 1, 1'b0, 32'h0, 1'b1, 1'b1);
    repeat (3) begin
      tick(); #1;
      check("t2_in_ready_hold", 32'(in_ready), 32'd0);
      chk_fwd("t2_busy_hold", 1, 1'b0, 32'h0, 1'b1, 1'b1);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
    chk_fwd("t2_rvalid_cycle", 1, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0; #1;
    chk_fwd("t2_W", 1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    check("t2_in_ready_resume", 32'(in_ready), 32'd1);
    tick(); tick();

    // back-to-back writers of r3: youngest value wins
    in_wr = '{valid: 1'b1, src: SRC_NOP, value: 32'h2, dst: 5'd3};
    in_valid = 1'b1;
    expect_wr(5'd3, 32'h2);
    expect_wr(5'd3, 32'h1);
    tick();
    in_wr = '{valid: 1'b1, src: SRC_NOP, value: 32'h1, dst: 5'd3};
    tick();
    in_valid = 1'b0; ra2 = 5'd3; #1;
    chk_fwd("t3_E_over_M", 2, 1'b1, 32'h1, 1'b0, 1'b1);
    tick(); #1;
    chk_fwd("t3_M_over_W", 2, 1'b1, 32'h1, 1'b0, 1'b1);
    tick(); tick();

    // dst=0 and wr.valid=0 records never write or forward
    alu_result = 32'h55;
    in_wr = '{valid: 1'b1, src: SRC_ALU, value: 32'h0, dst: 5'd0};
    in_valid = 1'b1;
    tick();
    in_wr = '{valid: 1'b0, src: SRC_ALU, value: 32'h0, dst: 5'd7};
    tick();
    in_valid = 1'b0; ra1 = 5'd0; ra2 = 5'd7; #1;
    chk_fwd("t5_ra0", 1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_fwd("t5_nowrite", 2, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) tick();

    // flush a waiting LW, then a stale response must not reach the new LW
    ra1 = 5'd10;
    in_wr = '{valid: 1'b1, src: SRC_MEM, value: 32'h0, dst: 5'd10};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); #1;
    chk_fwd("t4_wait", 1, 1'b0, 32'h0, 1'b1, 1'b1);
    flush = 1'b1; alu_result = 32'h12;
    in_wr = '{valid: 1'b1, src: SRC_ALU, value: 32'h0, dst: 5'd12};
    in_valid = 1'b1; #1;
    check("t4_in_ready_flush", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; #1;
    chk_fwd("t4_flushed", 1, 1'b0, 32'h0, 1'b0, 1'b0);
    ra1 = 5'd11;
    in_wr = '{valid: 1'b1, src: SRC_MEM, value: 32'h0, dst: 5'd11};
    in_valid = 1'b1;
    expect_wr(5'd11, 32'h0000_BBBB);
    tick();
    in_valid = 1'b0;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_AAAA; #1;
    chk_fwd("t4_stale", 1, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0; #1;
    chk_fwd("t4_still_wait", 1, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_BBBB;
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0; #1;
    chk_fwd("t4_W", 1, 1'b1, 32'h0000_BBBB, 1'b0, 1'b1);
    tick(); tick();

    // reset with a record in M: it must vanish without a write
    alu_result = 32'h20;
    in_wr = '{valid: 1'b1, src: SRC_ALU, value: 32'h0, dst: 5'd20};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1; #1;
    check("rst_mid_rf_we", 32'(rf_we), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    tick();
    reset = 1'b0;
    repeat (4) tick();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/write_reg_pipe.md
# write_reg_pipe

Tracks every decoded `write_reg_t` record (valid, src, value, dst) from decode through the E, M and W stages and resolves each record's final value. Operand values come from the ALU for `SRC_ALU`, from the memory response for `SRC_MEM`, and are carried unchanged for `SRC_NOP`. The block drives the GPR file write port at W. It also answers two decode-side operand queries with forwarded data or a busy (stall) indication. It sits directly downstream of the decode write-register logic and upstream of the register file.

## Interface
Parameters:
- none; widths come from `word_t` (32) and `creg_addr_t` (5).

Ports:
- `clk`  in  1  the block's single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  decode offers a record.
- `in_ready`  out  1  the record is accepted when `in_valid & in_ready`.
- `in_wr`  in  `write_reg_t`  the offered record.
- `alu_result`  in  32  ALU output for the record currently in E.
- `mem_rvalid`  in  1  memory load data is valid this cycle.
- `mem_rdata`  in  32  memory load data.
- `flush`  in  1  kill E and M; W still commits.
- `ra1`, `ra2`  in  5  decode source register queries.
- `fwd1_hit`, `fwd2_hit`  out  1  an in-flight record supplies the operand.
- `fwd1_data`, `fwd2_data`  out  32  the forwarded value.
- `fwd1_busy`, `fwd2_busy`  out  1  the operand is pending; decode must stall.
- `rf_we`  out  1  register file write enable.
- `rf_waddr`  out  5  register file write address.
- `rf_wdata`  out  32  register file write data.

## Operation
- **Stages.** E, M and W are each one register. Each holds valid, src, value, dst, and (in M) a `have` flag.
- **Non-writing records.** A record with `wr.valid=0` or `dst=0` is still accepted and moves through the stages. It never writes the register file and never forwards.
- **Advance rules:**
  - W always retires in one cycle.
  - M advances unless it holds `SRC_MEM` with `have=0`.
  - E advances when M is empty or M advances.
  - `in_ready` = (E empty | E advances) & ~`flush`.
- **E→M transfer:**
  - `SRC_ALU`: value latches `alu_result`; `have=1`.
  - `SRC_NOP`: value is kept; `have=1`.
  - `SRC_MEM`: `have=0`.
- **Memory response in M.** When M holds `SRC_MEM` with `have=0` and `mem_rvalid=1`, value latches `mem_rdata`, `have` is set, and M may advance in the same cycle. In that case the W value is `mem_rdata`.
- **Write port.** `rf_we` = W.valid & W.wr.valid & (W.dst≠0). `rf_waddr` = W.dst and `rf_wdata` = W.value, both driven combinationally from W.
- **Forwarding.** The youngest matching stage wins: E, then M, then W. A stage matches when it is valid, `wr.valid=1`, `dst≠0` and `dst` equals the query address. For the winning stage:
  - E `SRC_NOP`: hit, data = value.
  - E `SRC_ALU`: hit, data = `alu_result`.
  - E `SRC_MEM`: busy.
  - M with `have=1`: hit, data = value.
  - M with `have=0`: busy.
  - W: hit, data = value.
  - When there is no match, hit and busy are both 0.
- **Flush:**
  - At the next edge, E and M are cleared and the new input is not accepted.
  - If the flushed M was awaiting memory, a `drop` flag is set. The next `mem_rvalid` is discarded and clears `drop`.
  - While `drop=1`, a new `SRC_MEM` record in M ignores `mem_rvalid` until `drop` clears.
- **Reset.** Reset mid-operation discards all in-flight records without any register file write.

## Timing
- **Reset values:** all stage valids 0, `drop`=0, `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, all fwd outputs 0, `in_ready`=1.
- **Latency:** a record accepted at edge t is in E from t, in M from t+1 and in W from t+2. `rf_we` is high from t+2 to t+3, so the write commits at edge t+3.
- **Memory stall:** each cycle without `mem_rvalid` adds one cycle to M occupancy and back-pressures E and then `in_ready`.
- **Throughput:** one record per cycle with no stalls.
- **Combinational paths:** all fwd outputs are combinational from stage state, `alu_result` and `ra*`. There is no combinational path from `mem_rdata` to the fwd outputs.

## Configuration
- `WRITE_REG_FWD_EN` defined: the forwarding behaviour described above.
- `WRITE_REG_FWD_EN` undefined:
  - `fwd*_hit` and `fwd*_data` are tied to 0.
  - `fwd*_busy`=1 whenever any stage matches the query address, giving a pure interlock.

## Test plan
- Accept ADDU record (src=ALU, dst=5) with `alu_result`=0x1234 at edge 0 → at edge 1 query ra1=5 gives hit=1, data=0x1234; `rf_we`=1, waddr=5, wdata=0x1234 during cycle 2→3.
- Accept LW record (src=MEM, dst=8), hold `mem_rvalid` low 3 cycles → `in_ready`=0 after E fills, ra1=8 busy=1; then `mem_rvalid`=1 with data 0xDEADBEEF → busy clears; the write of 0xDEADBEEF to r8 occurs one cycle later.
- Back-to-back writes to r3 with values 0x1 (E) and 0x2 (M), query ra2=3 → data=0x1 (youngest wins).
- Flush while M awaits LW, then a new LW enters M; stale `mem_rvalid` with 0xAAAA arrives, then fresh `mem_rvalid` with 0xBBBB → only 0xBBBB is written.
- Record with dst=0 and src=ALU → `rf_we` stays 0 and queries for ra=0 show hit=0, busy=0.
- Build without `WRITE_REG_FWD_EN`, ADDU dst=5 in flight → ra1=5 gives busy=1 and hit=0 until W retires.
